descaler: RTL
=============

# descaler

Pipelined right-shift descaler with rounding and saturation: the inverse of the team's 16-to-32-bit left shifter. It takes a 32-bit scaled word (butterfly/twiddle product) plus a 4-bit shift amount and returns the 16-bit field starting at bit `shift`. Rounding and unsigned saturation are applied to that field. It sits at the output of each FFT stage, before the result is written back to memory, and uses valid/ready handshakes on both sides.

## Interface
Parameters:
- `SAT_CNT_W`, default 8: width of the saturation event counter.

Ports:
- `clk`  in  1: clock. One clock domain only.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: input word valid.
- `in_ready`  out  1: block accepts the input this cycle.
- `d_in`  in  32: unsigned scaled word.
- `shift`  in  4: right-shift amount, 0–15.
- `out_valid`  out  1: output word valid.
- `out_ready`  in  1: downstream accepts the output.
- `d_out`  out  16: descaled, rounded, saturated result.
- `ovf`  out  1: saturation occurred for the current `d_out`. Qualified by `out_valid`.
- `sat_cnt`  out  SAT_CNT_W: count of accepted outputs with `ovf=1`. Saturates at all-ones.

## Operation
- Stage 1 (S1) registers:
  - `t = d_in >> shift` (32-bit).
  - `r = d_in[shift-1]` when `shift>0`; `r=0` when `shift=0`.
  - `hi = |t[31:16]`.
- Stage 2 (S2):
  - `sum = {1'b0, t[15:0]} + r` (17-bit).
  - If `hi` or `sum[16]`: `d_out=16'hFFFF` and `ovf=1`.
  - Otherwise: `d_out=sum[15:0]` and `ovf=0`.
- Rounding is round-half-up on the magnitude. All data is unsigned.
- Global advance enable: `adv = !out_valid || out_ready`.
  - `in_ready = adv`.
  - S1 and S2 registers load only when `adv=1`.
  - A bubble (`in_valid=0`) propagates as `valid=0`.
- Input handshake: a word is accepted when `in_valid && in_ready`.
- Output handshake: a word completes when `out_valid && out_ready`.
- While stalled (`out_valid && !out_ready`), `d_out`, `ovf` and `out_valid` hold stable.
- `sat_cnt` increments by 1 on each output handshake with `ovf=1`. It holds at `2^SAT_CNT_W-1` and never wraps.
- No data is dropped or duplicated under any `in_valid`/`out_ready` pattern.
- The block round-trips with the left shifter: any 16-bit `D` shifted left by `s` and then descaled by `s` returns `D` with `ovf=0`.

## Timing
- Latency: 2 cycles from input handshake to `out_valid`, when not stalled.
- Throughput: 1 word/cycle while `out_ready=1`.
- Reset values: `out_valid=0`, `d_out=0`, `ovf=0`, `sat_cnt=0`, internal valid bits 0.
- `in_ready` is 1 in the cycle after reset is released.
- Reset mid-operation: both stages are flushed on the next edge. In-flight words are discarded and no partial output appears.
- Combinational paths: `in_ready` depends on `out_ready` (one gate level). There is no other input-to-output path.
- Simultaneous handshakes: an input accept and an output handshake in the same cycle are legal and preserve ordering.

## Configuration
- `DESCALER_ROUND_EN` defined:
  - Round-half-up as described above.
  - `sum[16]` can force saturation.
- `DESCALER_ROUND_EN` undefined:
  - `r` is tied to 0, giving pure truncation.
  - `ovf` depends only on `hi`.
  - Latency and handshake behaviour are unchanged.

## Test plan
- Basic extract: `d_in=32'h0001_2340`, `shift=4`, `out_ready=1` → 2 cycles later `d_out=16'h1234`, `ovf=0`.
- Rounding: `d_in=32'h0000_0018`, `shift=4` → `d_out=16'h0002` with `DESCALER_ROUND_EN` defined; `16'h0001` without it. `ovf=0` in both builds.
- Saturation:
  - `d_in=32'h0001_0000`, `shift=0` → `d_out=16'hFFFF`, `ovf=1`, `sat_cnt=1`.
  - `d_in=32'h0001_FFFF`, `shift=1` → `d_out=16'hFFFF`, `ovf=1` (round carry) with the macro defined; `16'hFFFF`, `ovf=0` without it.
- Round-trip: for all 16 shifts with `D=16'hA5A5`, input `{16'h0, D} << s` → `d_out=16'hA5A5`, `ovf=0`, `sat_cnt` unchanged.
- Backpressure: stream 8 words, toggling `out_ready` 1/0 every cycle and `in_valid` randomly → 8 outputs in order, values match the model, and outputs hold stable while stalled.
- Reset and counter:
  - Assert `rst` with 2 words in flight → no output afterwards, all outputs at reset values.
  - With `SAT_CNT_W=2`, 5 saturating outputs → `sat_cnt=3`.

Source files
------------

// File: rtl/descaler_if.sv
// descaler_if: valid/ready input and output channels of the descaler
interface descaler_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] d_in;
    logic [3:0]  shift;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] d_out;
    logic        ovf;
    modport slave (input in_valid, d_in, shift, out_ready, output in_ready, out_valid, d_out, ovf);
    modport master (output in_valid, d_in, shift, out_ready, input in_ready, out_valid, d_out, ovf);
endinterface

// File: rtl/descaler.sv
// descaler: two-stage right-shift descaler with round-half-up (DESCALER_ROUND_EN) and unsigned saturation
module descaler #(
    parameter int SAT_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    descaler_if.slave            bus,
    output logic [SAT_CNT_W-1:0] sat_cnt
);
    logic                 adv;
    logic                 v1_q, v1_d, r_q, r_d, hi_q, hi_d;
    logic                 v2_q, v2_d, ovf_q, ovf_d;
    logic [31:0]          t_q, t_d;
    logic [15:0]          dout_q, dout_d;
    logic [SAT_CNT_W-1:0] sat_q, sat_d;
    logic [16:0]          sum;

    // Both stages advance together whenever the output slot is free or being drained
    always_comb begin
        adv    = !v2_q || bus.out_ready;
        v1_d   = v1_q;
        t_d    = t_q;
        r_d    = r_q;
        hi_d   = hi_q;
        v2_d   = v2_q;
        dout_d = dout_q;
        ovf_d  = ovf_q;
        sat_d  = sat_q;
        sum    = {1'b0, t_q[15:0]} + {16'd0, r_q};
        if (adv) begin
            v1_d = bus.in_valid;
            if (bus.in_valid) begin
                t_d  = bus.d_in >> bus.shift;
`ifdef DESCALER_ROUND_EN
                r_d  = (bus.shift != 4'd0) && bus.d_in[{1'b0, bus.shift - 4'd1}];
`else
                r_d  = 1'b0;
`endif
                hi_d = |t_d[31:16];
            end
            v2_d = v1_q;
            if (v1_q) begin
                ovf_d  = hi_q || sum[16];
                dout_d = ovf_d ? 16'hFFFF : sum[15:0];
            end
        end
        if (v2_q && bus.out_ready && ovf_q && sat_q != '1)
            sat_d = sat_q + SAT_CNT_W'(1);
    end

    // Pipeline and counter registers, flushed by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q   <= 1'b0;
            t_q    <= '0;
            r_q    <= 1'b0;
            hi_q   <= 1'b0;
            v2_q   <= 1'b0;
            dout_q <= '0;
            ovf_q  <= 1'b0;
            sat_q  <= '0;
        end else begin
            v1_q   <= v1_d;
            t_q    <= t_d;
            r_q    <= r_d;
            hi_q   <= hi_d;
            v2_q   <= v2_d;
            dout_q <= dout_d;
            ovf_q  <= ovf_d;
            sat_q  <= sat_d;
        end
    end

    assign bus.in_ready  = adv;
    assign bus.out_valid = v2_q;
    assign bus.d_out     = dout_q;
    assign bus.ovf       = ovf_q;
    assign sat_cnt       = sat_q;
endmodule
